// File: rtl/ave8_thresh_mon_pkg.sv
// Shared constants and FSM encoding for the averaged-sample threshold monitor.
package ave8_thresh_mon_pkg;
  localparam int SAMPLE_W     = 8;
  localparam int DEF_WARMUP   = 8;
  localparam int DEF_DEBOUNCE = 3;
  localparam int DEF_WINDOW   = 16;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_BELOW  = 2'd1,
    ST_ABOVE  = 2'd2
  } state_t;
endpackage

// File: rtl/ave8_thresh_stats.sv
// Per-window min/max/rise-event accumulators and the report register with its
// valid/ready handoff to the control side.
module ave8_thresh_stats
  import ave8_thresh_mon_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_stb,
  input  logic                rise_stb,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                rpt_ready,
  output logic                rpt_valid,
  output logic [SAMPLE_W-1:0] rpt_min,
  output logic [SAMPLE_W-1:0] rpt_max,
  output logic [7:0]          rpt_events,
  output logic                rpt_ovf
);
  localparam int WC_W = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);

  logic [SAMPLE_W-1:0] acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [7:0]          acc_ev_q, acc_ev_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic                rpt_valid_q, rpt_valid_d, rpt_ovf_q, rpt_ovf_d;
  logic [SAMPLE_W-1:0] rpt_min_q, rpt_min_d, rpt_max_q, rpt_max_d;
  logic [7:0]          rpt_ev_q, rpt_ev_d;
  logic [SAMPLE_W-1:0] min_nx, max_nx;
  logic [7:0]          ev_nx;

  // Handshake: a report moves on any edge where rpt_valid && rpt_ready; a
  // completing window always wins and reloads the report, flagging overwrite
  // only if the old report was still pending and not being taken that cycle.
  always_comb begin
    acc_min_d   = acc_min_q;
    acc_max_d   = acc_max_q;
    acc_ev_d    = acc_ev_q;
    wcnt_d      = wcnt_q;
    rpt_valid_d = rpt_valid_q;
    rpt_ovf_d   = rpt_ovf_q;
    rpt_min_d   = rpt_min_q;
    rpt_max_d   = rpt_max_q;
    rpt_ev_d    = rpt_ev_q;
    min_nx      = (sample < acc_min_q) ? sample : acc_min_q;
    max_nx      = (sample > acc_max_q) ? sample : acc_max_q;
    ev_nx       = (rise_stb && acc_ev_q != 8'hFF) ? acc_ev_q + 8'd1 : acc_ev_q;

    if (rpt_valid_q && rpt_ready) rpt_valid_d = 1'b0;

    if (sample_stb) begin
      if (wcnt_q == WC_LAST) begin
        rpt_min_d   = min_nx;
        rpt_max_d   = max_nx;
        rpt_ev_d    = ev_nx;
        rpt_ovf_d   = rpt_valid_q && !rpt_ready;
        rpt_valid_d = 1'b1;
        acc_min_d   = '1;
        acc_max_d   = '0;
        acc_ev_d    = '0;
        wcnt_d      = '0;
      end else begin
        acc_min_d = min_nx;
        acc_max_d = max_nx;
        acc_ev_d  = ev_nx;
        wcnt_d    = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_min_q   <= '1;
      acc_max_q   <= '0;
      acc_ev_q    <= '0;
      wcnt_q      <= '0;
      rpt_valid_q <= 1'b0;
      rpt_ovf_q   <= 1'b0;
      rpt_min_q   <= '0;
      rpt_max_q   <= '0;
      rpt_ev_q    <= '0;
    end else begin
      acc_min_q   <= acc_min_d;
      acc_max_q   <= acc_max_d;
      acc_ev_q    <= acc_ev_d;
      wcnt_q      <= wcnt_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_ovf_q   <= rpt_ovf_d;
      rpt_min_q   <= rpt_min_d;
      rpt_max_q   <= rpt_max_d;
      rpt_ev_q    <= rpt_ev_d;
    end
  end

  assign rpt_valid  = rpt_valid_q;
  assign rpt_ovf    = rpt_ovf_q;
  assign rpt_min    = rpt_min_q;
  assign rpt_max    = rpt_max_q;
  assign rpt_events = rpt_ev_q;
endmodule

// File: rtl/ave8_thresh_mon.sv
// Debounced hysteresis comparator on the averaged sample stream, with
// warm-up blanking and windowed statistics reporting.
module ave8_thresh_mon
  import ave8_thresh_mon_pkg::*;
#(
  parameter int WARMUP   = DEF_WARMUP,
  parameter int DEBOUNCE = DEF_DEBOUNCE,
  parameter int WINDOW   = DEF_WINDOW
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [SAMPLE_W-1:0] ave_in,
  input  logic [SAMPLE_W-1:0] thr_hi,
  input  logic [SAMPLE_W-1:0] thr_lo,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic                cfg_err,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [SAMPLE_W-1:0] rpt_min,
  output logic [SAMPLE_W-1:0] rpt_max,
  output logic [7:0]          rpt_events,
  output logic                rpt_ovf
);
  localparam int WU_W = $clog2(WARMUP + 1);
  localparam logic [WU_W-1:0] WU_LAST  = WU_W'(WARMUP - 1);
  localparam logic [3:0]      DBC_LAST = 4'(DEBOUNCE - 1);

  state_t          state_q, state_d;
  logic [WU_W-1:0] wu_cnt_q, wu_cnt_d;
  logic [3:0]      dbc_q, dbc_d;
  logic            level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic            cfg_err_q, cfg_err_d;
  logic            sample_stb;

  always_comb begin
    state_d    = state_q;
    wu_cnt_d   = wu_cnt_q;
    dbc_d      = dbc_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    cfg_err_d  = thr_lo > thr_hi;
    sample_stb = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (wu_cnt_q == WU_LAST) begin
          state_d  = ST_BELOW;
          wu_cnt_d = '0;
        end else begin
          wu_cnt_d = wu_cnt_q + 1'b1;
        end
      end
      ST_BELOW: begin
        sample_stb = 1'b1;
        if (cfg_err_q || ave_in < thr_hi) begin
          dbc_d = '0;
        end else if (dbc_q == DBC_LAST) begin
          state_d = ST_ABOVE;
          dbc_d   = '0;
          rise_d  = 1'b1;
        end else begin
          dbc_d = dbc_q + 4'd1;
        end
      end
      ST_ABOVE: begin
        sample_stb = 1'b1;
        if (cfg_err_q || ave_in > thr_lo) begin
          dbc_d = '0;
        end else if (dbc_q == DBC_LAST) begin
          state_d = ST_BELOW;
          dbc_d   = '0;
          fall_d  = 1'b1;
        end else begin
          dbc_d = dbc_q + 4'd1;
        end
      end
      default: state_d = ST_WARMUP;
    endcase
    // level follows the state being entered so it lines up with rise/fall.
    level_d = (state_d == ST_ABOVE);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_WARMUP;
      wu_cnt_q  <= '0;
      dbc_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wu_cnt_q  <= wu_cnt_d;
      dbc_q     <= dbc_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign cfg_err = cfg_err_q;

  ave8_thresh_stats #(.WINDOW(WINDOW)) u_stats (
    .clk        (CLOCK),
    .rst        (RESET),
    .sample_stb (sample_stb),
    .rise_stb   (rise_d),
    .sample     (ave_in),
    .rpt_ready  (rpt_ready),
    .rpt_valid  (rpt_valid),
    .rpt_min    (rpt_min),
    .rpt_max    (rpt_max),
    .rpt_events (rpt_events),
    .rpt_ovf    (rpt_ovf)
  );
endmodule

// File: tb/tb_ave8_thresh_mon.sv
// Bench for ave8_thresh_mon: directed corner sequences, a vector table and a
// randomized run, all checked against a window-queue reference model.
module tb_ave8_thresh_mon;
  localparam int WARMUP   = 8;
  localparam int DEBOUNCE = 3;
  localparam int WINDOW   = 16;

  // clock / reset
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] ave_in = '0, thr_hi = 8'd100, thr_lo = 8'd50;
  logic       rpt_ready = 1'b0;
  logic       level, rise, fall, cfg_err, rpt_valid, rpt_ovf;
  logic [7:0] rpt_min, rpt_max, rpt_events;

  always #5 CLOCK = ~CLOCK;

  ave8_thresh_mon #(.WARMUP(WARMUP), .DEBOUNCE(DEBOUNCE), .WINDOW(WINDOW)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ave_in(ave_in), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .level(level), .rise(rise), .fall(fall), .cfg_err(cfg_err),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_min(rpt_min),
    .rpt_max(rpt_max), .rpt_events(rpt_events), .rpt_ovf(rpt_ovf)
  );

  int total = 0;
  int bad   = 0;

  // reference model: samples since reset, run length of qualifying samples,
  // and the raw samples of the current window kept in a queue
  int         m_cyc, m_run, m_ev;
  bit         m_level, m_rise, m_fall, m_cfg, m_valid, m_ovf;
  int         m_min, m_max, m_rev;
  logic [7:0] win_q[$];

  typedef struct {
    logic [7:0] ave;
    logic       exp_rise;
    logic       exp_level;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_run = 0; m_ev = 0;
    m_level = 0; m_rise = 0; m_fall = 0; m_cfg = 0; m_valid = 0; m_ovf = 0;
    m_min = 0; m_max = 0; m_rev = 0;
    win_q.delete();
  endtask

  task automatic model_update();
    bit qual;
    bit taken;
    int mn, mx;
    m_rise = 0;
    m_fall = 0;
    if (m_cyc < WARMUP) begin
      m_cyc++;
    end else begin
      qual = m_level ? (ave_in <= thr_lo) : (ave_in >= thr_hi);
      if (m_cfg || !qual) m_run = 0;
      else begin
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_run = 0;
          m_level = !m_level;
          if (m_level) m_rise = 1; else m_fall = 1;
        end
      end
      win_q.push_back(ave_in);
      if (m_rise && m_ev < 255) m_ev++;
      taken = m_valid && rpt_ready;
      if (win_q.size() == WINDOW) begin
        mn = 255; mx = 0;
        foreach (win_q[k]) begin
          if (win_q[k] < mn) mn = win_q[k];
          if (win_q[k] > mx) mx = win_q[k];
        end
        m_ovf = m_valid && !rpt_ready;
        m_valid = 1;
        m_min = mn; m_max = mx; m_rev = m_ev;
        m_ev = 0;
        win_q.delete();
      end else if (taken) begin
        m_valid = 0;
      end
    end
    m_cfg = (thr_lo > thr_hi);
  endtask

  // scoreboard compare of every output against the model
  task automatic check_all();
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("cfg_err", cfg_err, m_cfg);
    chk("rpt_valid", rpt_valid, m_valid);
    chk("rpt_ovf", rpt_ovf, m_ovf);
    chk("rpt_min", rpt_min, m_min);
    chk("rpt_max", rpt_max, m_max);
    chk("rpt_events", rpt_events, m_rev);
  endtask

  // driver tasks
  task automatic step();
    @(posedge CLOCK);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst_level", level, 0);
    chk("rst_valid", rpt_valid, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic warm_test();
    ave_in = 8'd200; thr_hi = 8'd100; thr_lo = 8'd50; rpt_ready = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk("wu_level", level, (i >= 11) ? 1 : 0);
      chk("wu_rise", rise, (i == 11) ? 1 : 0);
    end
  endtask

  initial begin
    vecs[0] = '{8'd120, 1'b0, 1'b0};
    vecs[1] = '{8'd120, 1'b0, 1'b0};
    vecs[2] = '{8'd40,  1'b0, 1'b0};
    vecs[3] = '{8'd120, 1'b0, 1'b0};
    vecs[4] = '{8'd120, 1'b0, 1'b0};
    vecs[5] = '{8'd120, 1'b1, 1'b1};

    model_reset();
    do_reset();

    // warm-up blanking then first rise on the 11th cycle
    warm_test();

    // hysteresis: 75 sits between thresholds, then three 50s fall
    for (int i = 0; i < 20; i++) begin
      ave_in = 8'd75;
      step();
      chk("hys_level", level, 1);
      chk("hys_fall", fall, 0);
    end
    for (int i = 0; i < 3; i++) begin
      ave_in = 8'd50;
      step();
      chk("hys_fall3", fall, (i == 2) ? 1 : 0);
    end

    // debounce glitch vector table
    do_reset();
    ave_in = 8'd0; thr_hi = 8'd100; thr_lo = 8'd50; rpt_ready = 1'b1;
    for (int i = 0; i < WARMUP; i++) step();
    for (int i = 0; i < 6; i++) begin
      ave_in = vecs[i].ave;
      step();
      chk("vec_rise", rise, vecs[i].exp_rise);
      chk("vec_level", level, vecs[i].exp_level);
    end

    // window report from a ramp, valid for exactly one cycle
    do_reset();
    ave_in = 8'd0; rpt_ready = 1'b1;
    for (int i = 0; i < WARMUP; i++) step();
    for (int v = 10; v <= 25; v++) begin
      ave_in = 8'(v);
      step();
      if (v < 25) chk("ramp_valid_lo", rpt_valid, 0);
    end
    chk("ramp_valid", rpt_valid, 1);
    chk("ramp_min", rpt_min, 10);
    chk("ramp_max", rpt_max, 25);
    chk("ramp_events", rpt_events, 0);
    chk("ramp_ovf", rpt_ovf, 0);
    ave_in = 8'd30;
    step();
    chk("ramp_valid_drop", rpt_valid, 0);

    // overwrite, then accept on the completing cycle
    rpt_ready = 1'b0;
    begin
      int n = 0;
      do begin
        ave_in = 8'($urandom_range(0, 90));
        step();
        n++;
      end while (win_q.size() != 0 && n < 20);
      chk("ow_len", n, WINDOW - 1);
    end
    chk("ow_first_valid", rpt_valid, 1);
    chk("ow_first_ovf", rpt_ovf, 0);
    for (int i = 0; i < WINDOW; i++) begin
      ave_in = 8'($urandom_range(0, 90));
      step();
    end
    chk("ow_second_valid", rpt_valid, 1);
    chk("ow_second_ovf", rpt_ovf, 1);
    for (int i = 0; i < WINDOW - 1; i++) begin
      ave_in = 8'($urandom_range(0, 90));
      step();
    end
    rpt_ready = 1'b1;
    ave_in = 8'd7;
    step();
    chk("sim_valid", rpt_valid, 1);
    chk("sim_ovf", rpt_ovf, 0);
    chk("sim_min_le7", (rpt_min <= 8'd7) ? 1 : 0, 1);

    // randomized run with changing thresholds
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        thr_hi = 8'($urandom_range(60, 200));
        thr_lo = 8'($urandom_range(20, int'(thr_hi)));
      end
      if (i % 256 == 192) thr_lo = 8'(int'(thr_hi) + $urandom_range(1, 40));
      ave_in = 8'($urandom_range(0, 255));
      rpt_ready = ($urandom_range(0, 2) == 0);
      step();
    end

    // config error, then reset while a report is pending
    thr_hi = 8'd100; thr_lo = 8'd150; rpt_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ave_in = 8'($urandom_range(0, 255));
      step();
      chk("cfg_err_hi", cfg_err, 1);
      if (i >= 1) begin
        chk("cfg_no_rise", rise, 0);
        chk("cfg_no_fall", fall, 0);
      end
    end
    chk("cfg_pending", rpt_valid, 1);
    do_reset();
    warm_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
